// File: rtl/motor_sequencer_pkg.sv
// Shared definitions for the motor sequencer and the speed-goal analysis stage:
// state encoding and default datapath parameters.
package motor_seq_pkg;

  localparam int DEF_W           = 10;
  localparam int DEF_STEP        = 4;
  localparam int DEF_TOL         = 8;
  localparam int DEF_STALL_MIN   = 2;
  localparam int DEF_STALL_TICKS = 64;
  localparam int DEF_HOLD_W      = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/motor_sequencer_if.sv
// Command handshake between the user/command side and the motor sequencer.
interface motor_sequencer_if
  import motor_seq_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int HOLD_W = DEF_HOLD_W
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic signed [W-1:0]  cmd_target;
  logic [HOLD_W-1:0]    cmd_hold;

  modport master (output cmd_valid, cmd_target, cmd_hold, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_target, cmd_hold, output cmd_ready);

endinterface

// File: rtl/motor_sequencer_goal_ramp.sv
// Combinational step of the speed goal toward a target by at most STEP.
// The difference is taken one bit wider so opposite-sign extremes cannot wrap;
// when the remaining distance is within STEP the goal lands exactly on target.
module goal_ramp #(
  parameter int W    = 10,
  parameter int STEP = 4
) (
  input  logic signed [W-1:0] goal_i,
  input  logic signed [W-1:0] target_i,
  output logic signed [W-1:0] next_o
);

  localparam logic signed [W:0]   STEP_X = (W+1)'(STEP);
  localparam logic signed [W-1:0] STEP_N = W'(STEP);

  logic signed [W:0] goal_x;
  logic signed [W:0] tgt_x;
  logic signed [W:0] diff;

  assign goal_x = {goal_i[W-1], goal_i};
  assign tgt_x  = {target_i[W-1], target_i};
  assign diff   = tgt_x - goal_x;

  // Full step while far away; snap to target once inside one step.
  always_comb begin
    next_o = target_i;
    if (diff > STEP_X)       next_o = goal_i + STEP_N;
    else if (diff < -STEP_X) next_o = goal_i - STEP_N;
  end

endmodule

// File: rtl/motor_sequencer.sv
// Motor sequencing controller: accepts a target speed command, ramps the
// signed speed goal toward it once per sample tick, holds for a commanded
// number of ticks, ramps back to zero, and faults out on a sustained stall.
module motor_sequencer
  import motor_seq_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int STEP        = DEF_STEP,
  parameter int TOL         = DEF_TOL,
  parameter int STALL_MIN   = DEF_STALL_MIN,
  parameter int STALL_TICKS = DEF_STALL_TICKS,
  parameter int HOLD_W      = DEF_HOLD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  motor_sequencer_if.slave    cmd,
  input  logic                stop,
  input  logic                clear_fault,
  input  logic signed [W-1:0] speed,
  output logic signed [W-1:0] goal,
  output logic                motor_en,
  output logic                at_speed,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int SW = $clog2(STALL_TICKS + 1);

  localparam logic [W:0]          TOL_V       = (W+1)'(TOL);
  localparam logic [W:0]          STALL_MIN_V = (W+1)'(STALL_MIN);
  localparam logic [SW-1:0]       STALL_LIM   = SW'(STALL_TICKS);
  localparam logic signed [W-1:0] MOST_NEG    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] NEG_CLAMP   = {1'b1, {(W-2){1'b0}}, 1'b1};

  function automatic logic [W:0] mag(input logic signed [W:0] v);
    return v[W] ? -v : v;
  endfunction

  state_e                state_q, state_d;
  logic signed [W-1:0]   goal_q, goal_d;
  logic signed [W-1:0]   tgt_q, tgt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [HOLD_W-1:0]     hcnt_q, hcnt_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic                  men_q, men_d;
  logic                  atspd_q, atspd_d;
  logic                  fault_q, fault_d;
  logic                  ready_q, ready_d;

  logic signed [W:0]     spd_x, goal_x;
  logic [W:0]            spd_mag, err_mag;
  logic signed [W-1:0]   ramp_tgt, step_goal;
  logic [SW-1:0]         stall_inc;
  logic                  stalled_tick;

  assign spd_x   = {speed[W-1], speed};
  assign goal_x  = {goal_q[W-1], goal_q};
  assign spd_mag = mag(spd_x);
  assign err_mag = mag(spd_x - goal_x);

  // STOP ramps toward zero with the same stepping rule as RAMP.
  assign ramp_tgt = (state_q == STOP) ? '0 : tgt_q;

  goal_ramp #(.W(W), .STEP(STEP)) u_ramp (
    .goal_i   (goal_q),
    .target_i (ramp_tgt),
    .next_o   (step_goal)
  );

  assign stalled_tick = tick && (goal_q != '0) && (spd_mag < STALL_MIN_V);
  assign stall_inc    = stall_q + SW'(1);

  // Next-state, goal and counter logic; stall fault overrides stop, which
  // overrides the normal per-state transition.
  always_comb begin
    state_d = state_q;
    goal_d  = goal_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    stall_d = stall_q;

    case (state_q)
      IDLE: begin
        goal_d = '0;
        if (cmd.cmd_valid && ready_q) begin
          tgt_d   = (cmd.cmd_target == MOST_NEG) ? NEG_CLAMP : cmd.cmd_target;
          hold_d  = cmd.cmd_hold;
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          goal_d = step_goal;
          if (goal_q == tgt_q && err_mag <= TOL_V) begin
            state_d = HOLD;
            hcnt_d  = hold_q;
          end
        end
      end
      HOLD: begin
        // A zero hold means no countdown: wait for stop.
        if (tick && hold_q != '0) begin
          hcnt_d = hcnt_q - HOLD_W'(1);
          if (hcnt_q == HOLD_W'(1)) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          goal_d = step_goal;
          if (goal_q == '0 && spd_mag <= TOL_V) state_d = IDLE;
        end
      end
      FAULT: begin
        goal_d = '0;
        if (clear_fault) state_d = IDLE;
      end
      default: begin
        goal_d  = '0;
        state_d = IDLE;
      end
    endcase

    if (state_q == RAMP || state_q == HOLD) begin
      if (tick) stall_d = stalled_tick ? stall_inc : '0;
      if (stalled_tick && stall_inc == STALL_LIM) begin
        state_d = FAULT;
        goal_d  = '0;
      end else if (stop) begin
        state_d = STOP;
      end
    end

    if (state_d != state_q) stall_d = '0;
  end

  // Registered status outputs decoded from the upcoming state.
  always_comb begin
    men_d   = (state_d == RAMP) || (state_d == HOLD) || (state_d == STOP);
    atspd_d = (state_d == HOLD);
    fault_d = (state_d == FAULT);
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset drops straight to IDLE with no ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      goal_q  <= '0;
      tgt_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      stall_q <= '0;
      men_q   <= 1'b0;
      atspd_q <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      goal_q  <= goal_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      stall_q <= stall_d;
      men_q   <= men_d;
      atspd_q <= atspd_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
    end
  end

  assign goal          = goal_q;
  assign motor_en      = men_q;
  assign at_speed      = atspd_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed + randomized bench for motor_sequencer. Expected goal profiles are
// computed arithmetically: after k ramp ticks the goal is sign(T)*min(4k,|T|),
// after j ramp-down ticks it is sign(T)*max(|T|-4j,0).
module tb_motor_sequencer;

  localparam int W = 10;
  localparam int HW = 16;
  localparam int STEP = 4;
  localparam int TOL = 8;
  localparam int STALL_TICKS = 64;

  logic clk = 1'b0;
  logic rst_n, tick, stop, clear_fault;
  logic signed [W-1:0] speed, goal;
  logic motor_en, at_speed, fault;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  motor_sequencer_if #(.W(W), .HOLD_W(HW)) cif ();

  motor_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .cmd         (cif),
    .stop        (stop),
    .clear_fault (clear_fault),
    .speed       (speed),
    .goal        (goal),
    .motor_en    (motor_en),
    .at_speed    (at_speed),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return (v < 0) ? -1 : 1;
  endfunction

  function automatic int ramp_val(input int t, input int k);
    return sgn(t) * ((STEP * k < iabs(t)) ? STEP * k : iabs(t));
  endfunction

  function automatic int down_val(input int t, input int j);
    return sgn(t) * ((iabs(t) - STEP * j > 0) ? iabs(t) - STEP * j : 0);
  endfunction

  function automatic int steps_to(input int t);
    return (iabs(t) + STEP - 1) / STEP;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse, preceded by a few random idle cycles.
  task automatic do_tick();
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic set_speed(input int v);
    speed = W'(v);
  endtask

  task automatic send_cmd(input int t, input int h);
    cif.cmd_valid  = 1'b1;
    cif.cmd_target = W'(t);
    cif.cmd_hold   = HW'(h);
    cyc();
    cif.cmd_valid  = 1'b0;
  endtask

  // Full command profile with speed tracking the goal.
  task automatic run_profile(input int t, input int h, input bit probe);
    int te, n;
    te = (t == -512) ? -511 : t;
    send_cmd(t, h);
    chk("acc_state", 32'(state), 1);
    chk("acc_motor_en", 32'(motor_en), 1);
    chk("acc_ready", 32'(cif.cmd_ready), 0);
    n = steps_to(te);
    for (int k = 1; k <= n; k++) begin
      set_speed(ramp_val(te, k - 1));
      do_tick();
      chk("ramp_goal", 32'(goal), ramp_val(te, k));
    end
    set_speed(te);
    if (probe) begin
      set_speed(te + TOL + 1);
      do_tick();
      chk("tol_out_state", 32'(state), 1);
      chk("tol_out_at_speed", 32'(at_speed), 0);
      set_speed(te + TOL);
    end
    do_tick();
    chk("hold_state", 32'(state), 2);
    chk("hold_at_speed", 32'(at_speed), 1);
    chk("hold_goal", 32'(goal), te);
    if (h == 0) begin
      repeat (3) do_tick();
      chk("hold0_state", 32'(state), 2);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("hold0_stop_state", 32'(state), 3);
      chk("hold0_stop_at_speed", 32'(at_speed), 0);
    end else begin
      for (int i = 1; i <= h; i++) begin
        do_tick();
        chk("hold_count_state", 32'(state), (i < h) ? 2 : 3);
      end
    end
    for (int j = 1; j <= n; j++) begin
      set_speed(down_val(te, j - 1));
      do_tick();
      chk("down_goal", 32'(goal), down_val(te, j));
    end
    set_speed(0);
    do_tick();
    chk("end_state", 32'(state), 0);
    chk("end_ready", 32'(cif.cmd_ready), 1);
    chk("end_motor_en", 32'(motor_en), 0);
    chk("end_goal", 32'(goal), 0);
  endtask

  initial begin
    int cnt, mg, prev, rt, rh;
    rst_n = 1'b0; tick = 1'b0; stop = 1'b0; clear_fault = 1'b0;
    speed = '0;
    cif.cmd_valid = 1'b0; cif.cmd_target = '0; cif.cmd_hold = '0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_goal", 32'(goal), 0);
    chk("rst_motor_en", 32'(motor_en), 0);
    chk("rst_at_speed", 32'(at_speed), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // stop and clear_fault have no effect in IDLE
    stop = 1'b1; clear_fault = 1'b1;
    do_tick();
    stop = 1'b0; clear_fault = 1'b0;
    chk("idle_ign_state", 32'(state), 0);
    chk("idle_ign_motor_en", 32'(motor_en), 0);

    // directed profiles
    run_profile(20, 3, 1'b1);
    run_profile(-10, 2, 1'b0);
    run_profile(-512, 1, 1'b0);

    // randomized profiles
    for (int r = 0; r < 6; r++) begin
      rt = int'($urandom_range(0, 1023)) - 512;
      rh = int'($urandom_range(0, 4));
      run_profile(rt, rh, 1'b0);
    end

    // stall: speed held at zero while the goal climbs
    send_cmd(100, 1);
    set_speed(0);
    cnt = 0; mg = 0;
    for (int k = 1; k <= 65; k++) begin
      prev = mg;
      do_tick();
      if (prev != 0) cnt++; else cnt = 0;
      mg = ramp_val(100, k);
      if (cnt >= STALL_TICKS) begin
        chk("stall_fault", 32'(fault), 1);
        chk("stall_motor_en", 32'(motor_en), 0);
        chk("stall_goal", 32'(goal), 0);
        chk("stall_state", 32'(state), 4);
      end else begin
        chk("prestall_fault", 32'(fault), 0);
        chk("prestall_goal", 32'(goal), mg);
      end
    end
    repeat (3) cyc();
    chk("fault_stay", 32'(state), 4);
    clear_fault = 1'b1;
    cyc();
    clear_fault = 1'b0;
    chk("clear_state", 32'(state), 0);
    chk("clear_fault_out", 32'(fault), 0);
    chk("clear_ready", 32'(cif.cmd_ready), 1);

    // stop mid-ramp, then the STOP->IDLE speed tolerance edge
    send_cmd(100, 0);
    chk("post_fault_accept", 32'(state), 1);
    for (int k = 1; k <= 3; k++) begin
      set_speed(ramp_val(100, k - 1));
      do_tick();
    end
    chk("midramp_goal", 32'(goal), 12);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_state", 32'(state), 3);
    chk("stop_goal_held", 32'(goal), 12);
    for (int j = 1; j <= 3; j++) begin
      set_speed(down_val(12, j - 1));
      do_tick();
      chk("stop_down_goal", 32'(goal), down_val(12, j));
    end
    set_speed(TOL + 1);
    do_tick();
    chk("stop_tol_out", 32'(state), 3);
    set_speed(TOL);
    do_tick();
    chk("stop_tol_in", 32'(state), 0);

    // busy handshake: a pending command waits for IDLE
    send_cmd(40, 0);
    cif.cmd_valid = 1'b1; cif.cmd_target = W'(-30); cif.cmd_hold = '0;
    for (int k = 1; k <= 3; k++) begin
      set_speed(ramp_val(40, k - 1));
      do_tick();
      chk("busy_ready", 32'(cif.cmd_ready), 0);
      chk("busy_goal", 32'(goal), ramp_val(40, k));
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      set_speed(down_val(12, j - 1));
      do_tick();
    end
    set_speed(0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("busy_idle_state", 32'(state), 0);
    chk("busy_idle_ready", 32'(cif.cmd_ready), 1);
    cyc();
    chk("busy_accept_state", 32'(state), 1);
    cif.cmd_valid = 1'b0;
    for (int k = 1; k <= steps_to(-30); k++) begin
      set_speed(ramp_val(-30, k - 1));
      do_tick();
      chk("neg_ramp_goal", 32'(goal), ramp_val(-30, k));
    end
    set_speed(-30);
    do_tick();
    chk("neg_hold_state", 32'(state), 2);

    // asynchronous reset between clock edges while in HOLD
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_goal", 32'(goal), 0);
    chk("arst_motor_en", 32'(motor_en), 0);
    chk("arst_at_speed", 32'(at_speed), 0);
    chk("arst_ready", 32'(cif.cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_state", 32'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
